// File: rtl/exe_alu_status_stage.sv
// ============================================================================
// exe_alu_status_stage
//
// Execute-stage arithmetic unit with the NZCV status register and the
// EXE/MEM pipeline register.
//
// Computes the data-processing result for the current instruction, or the
// load/store address (val1 + val2) for memory instructions. When the S bit is
// set, it also updates NZCV. All results are registered for the memory stage.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   valid_in     : EXE inputs carry a real instruction
//   val1, val2   : Rn operand and the already-shifted/immediate operand
//   exe_cmd      : operation code (MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR)
//   s_bit        : update NZCV from this instruction
//   mem_r_en_in, mem_w_en_in, wb_en_in : control, passed through
//   is_mem       : load/store; the result is the address, flags untouched
//   dest_in      : destination register index
//   st_val_in    : store data
//   freeze       : hold every register this cycle
//   flush        : replace this cycle's instruction with a bubble
//                  (flush takes priority over freeze)
//   alu_result, st_val, dest             : registered data
//   wb_en, mem_r_en, mem_w_en, valid_out : registered control
//   status       : current {N,Z,C,V}
// ============================================================================
module exe_alu_status_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [3:0]       exe_cmd,
    input  logic             s_bit,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             wb_en_in,
    input  logic             is_mem,
    input  logic [3:0]       dest_in,
    input  logic [WIDTH-1:0] st_val_in,
    input  logic             freeze,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] st_val,
    output logic [3:0]       dest,
    output logic             wb_en,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             valid_out,
    output logic [3:0]       status
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // Registered state
    logic [WIDTH-1:0] alu_result_q;
    logic [WIDTH-1:0] st_val_q;
    logic [3:0]       dest_q;
    logic             wb_en_q;
    logic             mem_r_en_q;
    logic             mem_w_en_q;
    logic             valid_q;
    logic [3:0]       status_q;

    // Combinational next state
    logic [WIDTH-1:0] result_d;
    logic [3:0]       status_d;
    logic             status_we;

    // Arithmetic path shared by ADD/ADC/SUB/SBC
    logic             cin;
    logic [WIDTH-1:0] arith_b;
    logic             arith_c0;
    logic [WIDTH:0]   arith_sum;
    logic [WIDTH-1:0] mem_addr;

    // Carry-in comes from the committed flag, so a flag-setting instruction
    // at edge k feeds ADC/SBC at edge k+1 without a bypass.
    assign cin = status_q[1];

    assign mem_addr = val1 + val2;

    // Subtraction reuses the adder as val1 + ~val2 + carry.
    always_comb begin
        arith_b  = val2;
        arith_c0 = 1'b0;
        case (exe_cmd)
            CMD_ADC: begin arith_b = val2;  arith_c0 = cin;  end
            CMD_SUB: begin arith_b = ~val2; arith_c0 = 1'b1; end
            CMD_SBC: begin arith_b = ~val2; arith_c0 = cin;  end
            default: begin arith_b = val2;  arith_c0 = 1'b0; end
        endcase
    end

    assign arith_sum = {1'b0, val1} + {1'b0, arith_b} + {{WIDTH{1'b0}}, arith_c0};

    always_comb begin
        result_d = '0;
        status_d = status_q;
        if (is_mem) begin
            result_d = mem_addr;
        end else begin
            case (exe_cmd)
                CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                    result_d    = arith_sum[WIDTH-1:0];
                    status_d[3] = arith_sum[WIDTH-1];
                    status_d[2] = (arith_sum[WIDTH-1:0] == '0);
                    status_d[1] = arith_sum[WIDTH];
                    // With arith_b already inverted for subtraction, one
                    // overflow rule covers both directions.
                    status_d[0] = (val1[WIDTH-1] == arith_b[WIDTH-1]) &&
                                  (arith_sum[WIDTH-1] != val1[WIDTH-1]);
                end
                CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
                    case (exe_cmd)
                        CMD_MOV: result_d = val2;
                        CMD_MVN: result_d = ~val2;
                        CMD_AND: result_d = val1 & val2;
                        CMD_ORR: result_d = val1 | val2;
                        default: result_d = val1 ^ val2;
                    endcase
                    // C and V keep their previous values.
                    status_d[3] = result_d[WIDTH-1];
                    status_d[2] = (result_d == '0);
                end
                default: begin
                    result_d = '0;
                end
            endcase
        end
    end

    assign status_we = valid_in & s_bit & ~is_mem & ~freeze & ~flush;

    // EXE/MEM pipeline register. Data fields simply hold on flush; only the
    // control bits need to be cleared to make a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
            st_val_q     <= '0;
            dest_q       <= '0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            valid_q      <= 1'b0;
        end else if (flush) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            valid_q      <= 1'b0;
        end else if (!freeze) begin
            alu_result_q <= result_d;
            st_val_q     <= st_val_in;
            dest_q       <= dest_in;
            wb_en_q      <= wb_en_in & valid_in;
            mem_r_en_q   <= mem_r_en_in & valid_in;
            mem_w_en_q   <= mem_w_en_in & valid_in;
            valid_q      <= valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= 4'b0000;
        end else if (status_we) begin
            status_q <= status_d;
        end
    end

    assign alu_result = alu_result_q;
    assign st_val     = st_val_q;
    assign dest       = dest_q;
    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign valid_out  = valid_q;
    assign status     = status_q;

endmodule

// File: doc/exe_alu_status_stage.md
# exe_alu_status_stage

Execute-stage arithmetic unit with the NZCV status register and the EXE/MEM pipeline register. It consumes Val1 (Rn) and the Val2 operand already formed by the shifter/immediate stage. It computes the data-processing result or the memory address, updates the flags when the S bit is set, and registers everything for the memory stage. Freeze and flush come from the hazard unit; the status output feeds the decode-stage condition check.

## Interface
- `WIDTH`, 32: datapath width (`REGISTER_LEN`).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `valid_in` input 1: the EXE inputs carry a real instruction.
- `val1` input WIDTH: Rn operand.
- `val2` input WIDTH: second operand, already shifted or immediate.
- `exe_cmd` input 4: operation code.
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
  - CMP uses 0100 with `wb_en`=0. TST uses 0110 with `wb_en`=0.
  - Any other code gives a result of 0 and leaves the flags unchanged.
- `s_bit` input 1: update NZCV from this instruction.
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in` input 1 each: control, passed through.
- `is_mem` input 1: a load/store instruction; the result is the address `val1 + val2` regardless of `exe_cmd`, and the flags are never updated.
- `dest_in` input 4: destination register index.
- `st_val_in` input WIDTH: store data (Rd contents).
- `freeze` input 1: hold all state this cycle.
- `flush` input 1: replace this cycle's instruction with a bubble.
- `alu_result` output WIDTH: registered result or address.
- `st_val` output WIDTH: registered store data.
- `dest` output 4: registered destination index.
- `wb_en`, `mem_r_en`, `mem_w_en`, `valid_out` output 1 each: registered control.
- `status` output 4: current NZCV as {N,Z,C,V}, straight from the status register.

## Operation
- Carry-in `cin` is `status[1]` (C) as held in the register, not the value being computed this cycle.
- ADD: `val1+val2`.
- ADC: `val1+val2+cin`.
- SUB: `val1+~val2+1`.
- SBC: `val1+~val2+cin`, which is ARM borrow semantics.
- All arithmetic is done at WIDTH+1 bits; C is bit WIDTH of the sum. For SUB/SBC, C=1 means no borrow.
- V for ADD/ADC: operands have the same sign and the result sign differs.
- V for SUB/SBC: operands have different signs and the result sign differs from `val1`.
- MOV is `val2`. MVN is `~val2`. AND, ORR and EOR are bitwise on `val1`/`val2`.
- Logical ops and MOV/MVN update N and Z only; C and V keep their previous values.
- N is `result[WIDTH-1]`. Z is `result==0`.
- The status register is written when `valid_in & s_bit & ~is_mem & ~freeze & ~flush`.
- Pipeline-register update priority, highest first:
  1. Reset: all outputs are 0, including `status`=0000.
  2. `flush`: `valid_out`, `wb_en`, `mem_r_en`, `mem_w_en` become 0. Data fields may hold any value. Status is not written.
  3. `freeze`: every register, including status, holds its value.
  4. Otherwise: load the computed values. `valid_out` takes `valid_in`. The control outputs take `*_in & valid_in`.
- When `valid_in`=0 the block behaves exactly like a flush for control and status.

## Timing
- Result latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k.
- A flag update at edge k is visible on `status` after edge k. The next instruction (edge k+1) uses the new C for ADC/SBC, so back-to-back flag dependencies need no stall.
- Reset is asynchronous: outputs go to 0 immediately on `rst` falling, regardless of `clk`.
  - An instruction in flight when reset asserts is discarded.
  - The first edge after `rst` rises captures normally.
- If `freeze` and `flush` are asserted in the same cycle, `flush` wins.
- Arithmetic wraps modulo 2^WIDTH. There is no saturation.

## Test plan
- Reset: with `rst`=0 mid-stream, all outputs read 0 and `status`=0000 without waiting for a clock edge. After release, ADD 5+3 gives `alu_result`=8 on the next edge.
- ADDS: `val1`=0x7FFFFFFF, `val2`=1, s=1 → result 0x80000000, NZCV=1001. Then ADDS 0xFFFFFFFF+1 → result 0, NZCV=0110.
- Carry chain: ADDS 0xFFFFFFFF+1 (C=1), then on the immediately following cycle ADC 2+3 → 6. Separately, with C=0, SBC 5−3 → 1, and SUBS 3−5 → 0xFFFFFFFE, NZCV=1000.
- Logical keeps C/V: with NZCV=0011, ANDS 0xF0 & 0x0F → result 0, NZCV=0111. EOR with s=0 leaves NZCV unchanged.
- Memory op: `is_mem`=1, `exe_cmd`=0110, `val1`=0x100, `val2`=0x24, s=1 → `alu_result`=0x124, `mem_r_en` passed through, status unchanged.
- Hazards:
  - Freeze for 3 cycles holds every output and the status.
  - `flush` together with `freeze` produces `valid_out`=0, `wb_en`=0, `mem_w_en`=0.
  - A flushed SUBS 1−1 leaves Z unchanged.
